fx_mult_seq: RTL and testbench

- Clocked, iterative successor to the team's combinational sign-magnitude fixed-point multiplier.
- Multiplies two (N,Q) sign-magnitude operands using shift-add. It retires UNROLL multiplier bits per cycle and adds valid/ready handshakes on both sides.
- Adds optional round-to-nearest, negative-zero normalisation and optional saturation.
- Used in the stepper motion-profile datapath where a full N×N array multiplier is too costly.

---
 rtl/fx_mult_seq.sv | 148 ++++++++++++++
 tb/tb_fx_mult_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fx_mult_seq.sv
// Iterative sign-magnitude (N,Q) fixed-point multiplier: shift-add, UNROLL bits per cycle, valid/ready on both sides.
// Optional FX_MULT_SAT_EN: saturate the magnitude on overflow instead of wrapping.
module fx_mult_seq #(
  parameter int unsigned Q      = 15,
  parameter int unsigned N      = 32,
  parameter int unsigned UNROLL = 1,
  parameter bit          ROUND  = 1'b1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] multiplicand_in,
  input  logic [N-1:0] multiplier_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [N-1:0] result_out,
  output logic         overflow_out,
  output logic         valid_out,
  input  logic         ready_in
);

  localparam int unsigned MW    = N - 1;
  localparam int unsigned PW    = 2 * N - 2;
  localparam int unsigned ITERS = MW / UNROLL;
  localparam int unsigned CW    = $clog2(ITERS + 1);

  if ((MW % UNROLL) != 0) begin : g_bad_unroll
    $error("fx_mult_seq: UNROLL must divide N-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINAL, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic          sign_q, sign_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  logic [PW-1:0] acc_sum_c;
  logic          rbit_c;
  logic [N-1:0]  mag_c;
  logic [MW-1:0] mag_fin_c;
  logic          ovf_c;
  logic          unused_acc_c;

  // With no fractional bits there is nothing to round on.
  if (ROUND && (Q > 0)) begin : g_round
    assign rbit_c = acc_q[Q-1];
  end else begin : g_trunc
    assign rbit_c = 1'b0;
  end

  assign mag_c = N'(acc_q[N-2+Q:Q]) + N'(rbit_c);
  assign ovf_c = (|acc_q[PW-1:N-1+Q]) | mag_c[N-1];
  assign unused_acc_c = ^acc_q;

`ifdef FX_MULT_SAT_EN
  assign mag_fin_c = ovf_c ? {MW{1'b1}} : mag_c[MW-1:0];
`else
  assign mag_fin_c = mag_c[MW-1:0];
`endif

  // Partial products for the next UNROLL multiplier bits, LSB first.
  always_comb begin
    acc_sum_c = acc_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (mplier_q[i]) acc_sum_c = acc_sum_c + (mcand_q << i);
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          mcand_d  = PW'(multiplicand_in[MW-1:0]);
          mplier_d = multiplier_in[MW-1:0];
          sign_d   = multiplicand_in[N-1] ^ multiplier_in[N-1];
          acc_d    = '0;
          cnt_d    = CW'(ITERS);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << UNROLL;
        mplier_d = mplier_q >> UNROLL;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        // A zero magnitude always carries a positive sign.
        result_d = {sign_q & (mag_fin_c != '0), mag_fin_c};
        ovf_d    = ovf_c;
        valid_d  = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (ready_in) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_out    = (state_q == S_IDLE) && !rst_in;
  assign result_out   = result_q;
  assign overflow_out = ovf_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_fx_mult_seq.sv
// Self-checking bench for fx_mult_seq: directed cases plus randomized streams against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fx_mult_seq;

  localparam int N = 32;
  localparam int Q = 15;
  parameter int UNROLL = 1;
  parameter bit ROUND  = 1'b1;
  localparam int ITERS = (N - 1) / UNROLL;

`ifdef FX_MULT_SAT_EN
  localparam logic [N-1:0] OVF_EXP = 32'h7FFFFFFF;
`else
  localparam logic [N-1:0] OVF_EXP = 32'h00000000;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] mcand, mplier;
  logic         valid_in, ready_out, overflow_out, valid_out, ready_in;
  logic [N-1:0] result_out;

  int checks = 0;
  int errors = 0;
  logic [N:0] exp_q[$];

  fx_mult_seq #(.Q(Q), .N(N), .UNROLL(UNROLL), .ROUND(ROUND)) dut (
    .clk_in(clk), .rst_in(rst),
    .multiplicand_in(mcand), .multiplier_in(mplier),
    .valid_in(valid_in), .ready_out(ready_out),
    .result_out(result_out), .overflow_out(overflow_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, scale, round, then fit into N-1 magnitude bits.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned p, mag, lim;
    logic ovf, neg;
    p   = 64'(a[N-2:0]) * 64'(b[N-2:0]);
    mag = p >> Q;
    if (ROUND && Q > 0) mag = mag + ((p >> (Q - 1)) & 64'd1);
    lim = 64'd1 << (N - 1);
    ovf = (mag >= lim);
`ifdef FX_MULT_SAT_EN
    if (ovf) mag = lim - 64'd1;
`else
    mag = mag & (lim - 64'd1);
`endif
    neg = (a[N-1] ^ b[N-1]) && (mag != 64'd0);
    return {ovf, neg, (N-1)'(mag)};
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    v = $urandom;
    v[N-2:0] = v[N-2:0] >> $urandom_range(0, N - 2);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with ready_in low; latency counts the accept edge as edge 1.
  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [N-1:0] exp_r, input logic exp_o);
    int lat;
    logic [N:0] m;
    m = model(a, b);
    mcand = a; mplier = b; valid_in = 1'b1; ready_in = 1'b0;
    for (int w = 0; w < 50 && !ready_out; w++) tick();
    tick();
    valid_in = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(ready_out), 64'd0);
    while (!valid_out && lat < ITERS + 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(ITERS + 2));
    check({tag, "_result"}, 64'(result_out), 64'(exp_r));
    check({tag, "_ovf"}, 64'(overflow_out), 64'(exp_o));
    check({tag, "_model"}, 64'({overflow_out, result_out}), 64'(m));
  endtask

  task automatic release_result(input string tag, input logic [N-1:0] kept);
    ready_in = 1'b1;
    tick();
    check({tag, "_rel_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_rel_ready"}, 64'(ready_out), 64'd1);
    check({tag, "_rel_kept"}, 64'(result_out), 64'(kept));
    ready_in = 1'b0;
  endtask

  // Continuous stream with a scoreboard; fixed ready_in also checks accept spacing.
  task automatic stream(input int cycles, input bit rnd_ready);
    bit acc, ret;
    int last_acc;
    last_acc = -1;
    mcand = rand_op(); mplier = rand_op();
    valid_in = 1'b1; ready_in = 1'b1;
    for (int c = 0; c < cycles + 3 * ITERS + 20; c++) begin
      if (c == cycles) begin
        valid_in = 1'b0;
        ready_in = 1'b1;
      end
      acc = valid_in && ready_out;
      ret = valid_out && ready_in;
      if (valid_out) begin
        check("stream_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("stream_result", 64'({overflow_out, result_out}), 64'(exp_q[0]));
      end
      tick();
      if (ret && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model(mcand, mplier));
        if (!rnd_ready && last_acc >= 0) check("stream_period", 64'(c - last_acc), 64'(ITERS + 3));
        last_acc = c;
        mcand = rand_op(); mplier = rand_op();
      end
      if (rnd_ready && c < cycles) ready_in = 1'($urandom_range(0, 1));
    end
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    ready_in = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; mcand = '0; mplier = '0;
    tick(); tick();
    check("rst_result", 64'(result_out), 64'd0);
    check("rst_ovf", 64'(overflow_out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 64'(ready_out), 64'd1);

    op("mul_1p5x2", 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_result", 64'(result_out), 64'h00018000);
      check("bp_valid", 64'(valid_out), 64'd1);
      check("bp_ready", 64'(ready_out), 64'd0);
    end
    release_result("mul_1p5x2", 32'h00018000);

    op("neg_pos", 32'h8000C000, 32'h00010000, 32'h80018000, 1'b0);
    release_result("neg_pos", 32'h80018000);
    op("neg_neg", 32'h8000C000, 32'h80010000, 32'h00018000, 1'b0);
    release_result("neg_neg", 32'h00018000);
    op("overflow", 32'h40000000, 32'h00010000, OVF_EXP, 1'b1);
    release_result("overflow", OVF_EXP);
    op("round_half", 32'h00000001, 32'h00004000, ROUND ? 32'h00000001 : 32'h00000000, 1'b0);
    release_result("round_half", ROUND ? 32'h00000001 : 32'h00000000);
    op("neg_zero", 32'h80000001, 32'h00000001, 32'h00000000, 1'b0);
    release_result("neg_zero", 32'h00000000);

    // Abort an operation in CALC; nothing may come out afterwards.
    mcand = 32'h0000C000; mplier = 32'h00010000; valid_in = 1'b1;
    for (int w = 0; w < 50 && !ready_out; w++) tick();
    tick();
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(ready_out), 64'd0);
    tick();
    rst = 1'b0;
    ready_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < ITERS + 8; i++) begin
      tick();
      seen |= valid_out;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_result", 64'(result_out), 64'd0);
    op("after_abort", 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);
    release_result("after_abort", 32'h00018000);

    stream(8 * (ITERS + 3), 1'b0);
    stream(1500, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
